// File: rtl/gb_video_pkg.sv
// Shared frame-store geometry, capture FSM encoding and byte-address helper
// for the LCD frame capture block.
package gb_video_pkg;
    localparam int LCD_WIDTH      = 160;
    localparam int LCD_HEIGHT     = 144;
    localparam int BYTES_PER_LINE = LCD_WIDTH / 4;
    localparam int BANK_BYTES     = BYTES_PER_LINE * LCD_HEIGHT;
    localparam int FB_ADDR_W      = 14;
    localparam int OFF_W          = FB_ADDR_W - 1;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        CAPTURE  = 1'b1
    } cap_state_e;

    // Byte offset inside one bank: four 2-bit pixels per byte, bpl bytes per line.
    function automatic logic [OFF_W-1:0] fb_offset(input logic [7:0] x, input logic [7:0] y,
                                                   input int bpl);
        return OFF_W'(int'(y) * bpl + int'(x[7:2]));
    endfunction
endpackage

// File: rtl/fb_bank_ram.sv
// Two-bank byte frame store: one write port, one registered read port.
// The bank select sits in the address MSB and maps onto a packed array.
module fb_bank_ram
    import gb_video_pkg::*;
#(
    parameter int BANK_DEPTH = BANK_BYTES
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [FB_ADDR_W-1:0] waddr_i,
    input  logic [7:0]           wdata_i,
    input  logic                 re_i,
    input  logic [FB_ADDR_W-1:0] raddr_i,
    output logic [7:0]           rdata_o
);
    logic [7:0] mem [2*BANK_DEPTH];
    logic [7:0] rdata_q;

    function automatic int phys(input logic [FB_ADDR_W-1:0] a);
        return a[FB_ADDR_W-1] ? BANK_DEPTH + int'(a[FB_ADDR_W-2:0]) : int'(a[FB_ADDR_W-2:0]);
    endfunction

    always_ff @(posedge clk_i) begin
        if (we_i) mem[phys(waddr_i)] <= wdata_i;
        if (re_i) rdata_q <= mem[phys(raddr_i)];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/gb_frame_capture.sv
// Captures the LCD pixel stream into a double-buffered packed frame store,
// swaps banks per completed frame and serves 1-cycle-latency random reads.
module gb_frame_capture #(
    parameter int LCD_WIDTH  = gb_video_pkg::LCD_WIDTH,
    parameter int LCD_HEIGHT = gb_video_pkg::LCD_HEIGHT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] color_in,
    input  logic       px_valid_in,
    input  logic [7:0] x_pos_in,
    input  logic [7:0] y_pos_in,
    input  logic       rd_en,
    input  logic [7:0] rd_x,
    input  logic [7:0] rd_y,
    output logic [1:0] rd_color,
    output logic       rd_valid,
    output logic       frame_done,
    output logic [7:0] frame_count,
    output logic       display_bank,
    output logic       sync_error
);
    import gb_video_pkg::*;

    localparam int         BPL    = LCD_WIDTH / 4;
    localparam logic [7:0] X_LAST = 8'(LCD_WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(LCD_HEIGHT - 1);

    cap_state_e state_q;
    logic [7:0] exp_x_q, exp_y_q, frame_count_q;
    logic [5:0] pack_q;
    logic       wbank_q, frame_ready_q, frame_done_q, sync_error_q;
    logic       rd_valid_q, rd_zero_q;
    logic [1:0] rd_sub_q;
    logic [7:0] ram_rdata;

    logic sof, hit, miss, accept, last_x, eof, we, re, rd_in_rng;

    assign sof    = px_valid_in && x_pos_in == 8'd0 && y_pos_in == 8'd0;
    assign hit    = px_valid_in && x_pos_in == exp_x_q && y_pos_in == exp_y_q;
    assign miss   = state_q == CAPTURE && px_valid_in && !hit;
    // A mismatched (0,0) still counts as a fresh start of frame.
    assign accept = (state_q == CAPTURE) ? (hit || sof) : sof;
    assign last_x = x_pos_in == X_LAST;
    assign eof    = accept && last_x && y_pos_in == Y_LAST;
    assign we     = accept && x_pos_in[1:0] == 2'd3;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= WAIT_SOF;
            exp_x_q       <= 8'd0;
            exp_y_q       <= 8'd0;
            pack_q        <= 6'd0;
            wbank_q       <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_count_q <= 8'd0;
            frame_done_q  <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            frame_done_q <= eof;
            if (miss) sync_error_q <= 1'b1;
            if (accept) begin
                state_q <= CAPTURE;
                case (x_pos_in[1:0])
                    2'd0:    pack_q[1:0] <= color_in;
                    2'd1:    pack_q[3:2] <= color_in;
                    2'd2:    pack_q[5:4] <= color_in;
                    default: ;
                endcase
                if (last_x) begin
                    exp_x_q <= 8'd0;
                    exp_y_q <= (y_pos_in == Y_LAST) ? 8'd0 : y_pos_in + 8'd1;
                end else begin
                    exp_x_q <= x_pos_in + 8'd1;
                    exp_y_q <= y_pos_in;
                end
                if (eof) begin
                    wbank_q       <= ~wbank_q;
                    frame_ready_q <= 1'b1;
                    frame_count_q <= frame_count_q + 8'd1;
                end
            end else if (miss) begin
                state_q <= WAIT_SOF;
            end
        end
    end

    // The display bank is taken together with the address, so a read in the
    // swap cycle still sees the outgoing frame.
    assign rd_in_rng = rd_x <= X_LAST && rd_y <= Y_LAST;
    assign re        = rd_en && rd_in_rng && frame_ready_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
            rd_sub_q   <= 2'd0;
        end else begin
            rd_valid_q <= rd_en;
            rd_zero_q  <= !(rd_in_rng && frame_ready_q);
            rd_sub_q   <= rd_x[1:0];
        end
    end

    fb_bank_ram #(.BANK_DEPTH(BPL * LCD_HEIGHT)) u_ram (
        .clk_i   (clock),
        .we_i    (we),
        .waddr_i ({wbank_q, fb_offset(x_pos_in, y_pos_in, BPL)}),
        .wdata_i ({color_in, pack_q}),
        .re_i    (re),
        .raddr_i ({~wbank_q, fb_offset(rd_x, rd_y, BPL)}),
        .rdata_o (ram_rdata)
    );

    assign rd_color     = (rd_valid_q && !rd_zero_q) ? ram_rdata[{rd_sub_q, 1'b0} +: 2] : 2'd0;
    assign rd_valid     = rd_valid_q;
    assign frame_done   = frame_done_q;
    assign frame_count  = frame_count_q;
    assign display_bank = ~wbank_q;
    assign sync_error   = sync_error_q;
endmodule

// File: tb/tb_gb_frame_capture.sv
// Randomised bench for gb_frame_capture on a reduced 16x6 frame, checked
// against a pixel-level model of the capture/swap/read rules.
module tb_gb_frame_capture;
    localparam int W = 16;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clock = 1'b0, reset = 1'b0;
    logic [1:0] color_in = 2'd0;
    logic       px_valid_in = 1'b0, rd_en = 1'b0;
    logic [7:0] x_pos_in = 8'd0, y_pos_in = 8'd0, rd_x = 8'd0, rd_y = 8'd0;
    logic [1:0] rd_color;
    logic       rd_valid, frame_done, display_bank, sync_error;
    logic [7:0] frame_count;

    gb_frame_capture #(.LCD_WIDTH(W), .LCD_HEIGHT(H)) dut (
        .clock(clock), .reset(reset), .color_in(color_in), .px_valid_in(px_valid_in),
        .x_pos_in(x_pos_in), .y_pos_in(y_pos_in), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .rd_color(rd_color), .rd_valid(rd_valid), .frame_done(frame_done),
        .frame_count(frame_count), .display_bank(display_bank), .sync_error(sync_error)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;

    // Model: pixels of the frame being built, pixels of the displayed frame.
    bit m_cap, m_ready, m_serr, m_dbank, m_done;
    int m_ex, m_ey, m_cnt;
    int pend[N];
    int disp[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic m_reset();
        m_cap = 0; m_ready = 0; m_serr = 0; m_dbank = 1; m_done = 0;
        m_ex = 0; m_ey = 0; m_cnt = 0;
    endtask

    task automatic m_accept(input int x, input int y, input int c);
        int idx;
        idx = y * W + x;
        pend[idx] = c;
        if (idx == N - 1) begin
            disp = pend;
            m_cnt = (m_cnt + 1) % 256;
            m_dbank = !m_dbank;
            m_ready = 1;
            m_done = 1;
        end
        m_ex = ((idx + 1) % N) % W;
        m_ey = ((idx + 1) % N) / W;
    endtask

    task automatic m_pixel(input int x, input int y, input int c);
        if (!m_cap) begin
            if (x == 0 && y == 0) begin m_cap = 1; m_accept(x, y, c); end
        end else if (x == m_ex && y == m_ey) begin
            m_accept(x, y, c);
        end else begin
            m_serr = 1;
            if (x == 0 && y == 0) m_accept(x, y, c);
            else m_cap = 0;
        end
    endtask

    // One clock: drive, advance the model, check every output after the edge.
    task automatic tick(input bit rst, input bit v, input int x, input int y, input int c,
                        input bit ren, input int rx, input int ry);
        bit exp_rv;
        int exp_rc;
        reset = rst; px_valid_in = v; x_pos_in = 8'(x); y_pos_in = 8'(y); color_in = 2'(c);
        rd_en = ren; rd_x = 8'(rx); rd_y = 8'(ry);
        exp_rv = ren && !rst;
        exp_rc = 0;
        if (exp_rv && m_ready && rx < W && ry < H) exp_rc = disp[ry * W + rx];
        m_done = 0;
        if (rst) m_reset();
        else if (v) m_pixel(x, y, c);
        @(posedge clock);
        #1;
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_count", 32'(frame_count), 32'(m_cnt));
        chk("display_bank", 32'(display_bank), 32'(m_dbank));
        chk("sync_error", 32'(sync_error), 32'(m_serr));
        chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
        chk("rd_color", 32'(rd_color), 32'(exp_rc));
    endtask

    task automatic idle(input bit ren, input int rx, input int ry);
        tick(0, 0, 0, 0, 0, ren, rx, ry);
    endtask

    // mode: 0 (x+y)%4, 1 random, 2 all 3, 3 all 1. Sends raster pixels 0..npix-1.
    task automatic send_frame(input int mode, input int npix, input bit rnd_rd,
                              input int skip, input bit noise);
        int x, y, c;
        bit ren;
        for (int i = 0; i < npix; i++) begin
            if (i == skip) continue;
            x = i % W; y = i / W;
            while ($urandom_range(7) == 0)
                idle(rnd_rd && $urandom_range(1) == 1, $urandom_range(W + 1), $urandom_range(H + 1));
            if (noise && $urandom_range(39) == 0)
                tick(0, 1, $urandom_range(3) == 0 ? 0 : $urandom_range(W + 2),
                     $urandom_range(3) == 0 ? 0 : $urandom_range(H + 1), $urandom_range(3),
                     0, 0, 0);
            case (mode)
                0: c = (x + y) % 4;
                1: c = $urandom_range(3);
                2: c = 3;
                default: c = 1;
            endcase
            ren = rnd_rd && $urandom_range(1) == 1;
            tick(0, 1, x, y, c, ren, $urandom_range(W + 1), $urandom_range(H + 1));
        end
    endtask

    initial begin
        m_reset();
        for (int i = 0; i < N; i++) begin pend[i] = 0; disp[i] = 0; end
        repeat (3) tick(1, 0, 0, 0, 0, 0, 0, 0);

        // Reads before any frame and out of range
        idle(1, 0, 0);
        chk("pre_frame_valid", 32'(rd_valid), 32'd1);
        idle(1, W, 0);
        chk("oor_color", 32'(rd_color), 32'd0);

        // First full frame with gradient colours
        send_frame(0, N, 1, -1, 0);
        idle(0, 0, 0);
        chk("f1_count", 32'(frame_count), 32'd1);
        chk("f1_bank", 32'(display_bank), 32'd0);
        idle(1, 5, 3);
        chk("f1_read", 32'(rd_color), 32'd0);

        // Skipped pixel (5,2): error, no swap, then clean recovery
        send_frame(1, 2 * W + 8, 1, 2 * W + 5, 0);
        chk("skip_err", 32'(sync_error), 32'd1);
        chk("skip_count", 32'(frame_count), 32'd1);
        send_frame(1, N, 1, -1, 0);
        chk("recover_count", 32'(frame_count), 32'd2);
        chk("recover_err", 32'(sync_error), 32'd1);

        // Mid-frame (0,0) restarts in the same cycle
        send_frame(1, 20, 1, -1, 0);
        send_frame(1, N, 1, -1, 0);
        chk("resof_count", 32'(frame_count), 32'd3);

        // Read in the swap cycle sees the outgoing frame
        send_frame(2, N, 0, -1, 0);
        send_frame(3, N - 1, 0, -1, 0);
        tick(0, 1, W - 1, H - 1, 1, 1, 8, 3);
        chk("swap_read_old", 32'(rd_color), 32'd3);
        idle(1, 8, 3);
        chk("swap_read_new", 32'(rd_color), 32'd1);

        // Reset in the middle of a frame
        send_frame(1, N, 1, -1, 0);
        send_frame(1, 4 * W + 10, 1, -1, 0);
        tick(1, 1, 10, 4, 2, 1, 0, 0);
        chk("rst_count", 32'(frame_count), 32'd0);
        chk("rst_bank", 32'(display_bank), 32'd1);
        chk("rst_err", 32'(sync_error), 32'd0);
        idle(1, 0, 0);
        send_frame(1, N, 1, -1, 0);
        idle(0, 0, 0);
        chk("post_rst_count", 32'(frame_count), 32'd1);
        chk("post_rst_bank", 32'(display_bank), 32'd0);

        // Random stream corruption
        for (int f = 0; f < 10; f++) send_frame(1, N, 1, -1, 1);

        // 256 frames wrap the counter
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int f = 0; f < 256; f++) send_frame(1, N, 1, -1, 0);
        idle(1, 3, 2);
        chk("wrap_count", 32'(frame_count), 32'd0);
        chk("wrap_bank", 32'(display_bank), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
